// File: rtl/bomberman_pkg.sv
// bomberman_pkg: shared slot state encoding, pool size and owner constants for the bomb scheduler.
package bomberman_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FUSE = 2'd1, BLAST = 2'd2} slot_state_t;
    localparam int NUM_SLOTS = 6;
    localparam logic OWNER_P1 = 1'b0;
    localparam logic OWNER_P2 = 1'b1;
    localparam int COORD_W_DEF = 4;
endpackage

// File: rtl/bomb_slot.sv
// bomb_slot: one bomb slot with IDLE/FUSE/BLAST state, frame timer, tile coordinates and owner.
module bomb_slot
    import bomberman_pkg::*;
#(
    parameter int COORD_W      = COORD_W_DEF,
    parameter int FUSE_FRAMES  = 150,
    parameter int BLAST_FRAMES = 30,
    parameter int TW           = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic               i_tick,
    input  logic               i_force,
    input  logic               i_owner,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output slot_state_t        o_state,
    output logic               o_owner,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_enter_blast
);
    slot_state_t        r_state, w_state_n;
    logic [TW-1:0]      r_timer, w_timer_n;
    logic               r_owner, w_owner_n, w_expire;
    logic [COORD_W-1:0] r_x, r_y, w_x_n, w_y_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_owner <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_n;
            r_timer <= w_timer_n;
            r_owner <= w_owner_n;
            r_x     <= w_x_n;
            r_y     <= w_y_n;
        end
    end

    assign w_expire = i_tick && (r_timer == TW'(1));

    // A tick that expires the fuse wins over a chain force arriving on the same cycle.
    always_comb begin
        w_state_n = r_state;
        w_timer_n = r_timer;
        w_owner_n = r_owner;
        w_x_n     = r_x;
        w_y_n     = r_y;
        if (i_clear || (r_state == BLAST && w_expire)) begin
            w_state_n = IDLE;
            w_timer_n = '0;
            w_owner_n = 1'b0;
            w_x_n     = '0;
            w_y_n     = '0;
        end else if (r_state == IDLE) begin
            if (i_load) begin
                w_state_n = FUSE;
                w_timer_n = TW'(FUSE_FRAMES);
                w_owner_n = i_owner;
                w_x_n     = i_x;
                w_y_n     = i_y;
            end
        end else if (r_state == FUSE && w_expire) begin
            w_state_n = BLAST;
            w_timer_n = TW'(BLAST_FRAMES);
        end else if (r_state == FUSE && i_force) begin
            w_timer_n = TW'(1);
        end else if (i_tick) begin
            w_timer_n = r_timer - TW'(1);
        end
    end

    assign o_state       = r_state;
    assign o_owner       = r_owner;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_enter_blast = ~i_clear && r_state == FUSE && w_expire;
endmodule

// File: rtl/bomb_slot_scheduler.sv
// bomb_slot_scheduler: six-slot bomb pool with P1/P2 arbitration and read port; define CHAIN_REACTION_EN for blast-triggered chain detonation.
module bomb_slot_scheduler
    import bomberman_pkg::*;
#(
    parameter int FUSE_FRAMES    = 150,
    parameter int BLAST_FRAMES   = 30,
    parameter int MAX_PER_PLAYER = 3,
    parameter int COORD_W        = COORD_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_tick,
    input  logic               i_game_clear,
    input  logic               i_p1_place,
    input  logic [COORD_W-1:0] i_p1_x,
    input  logic [COORD_W-1:0] i_p1_y,
    input  logic               i_p2_place,
    input  logic [COORD_W-1:0] i_p2_x,
    input  logic [COORD_W-1:0] i_p2_y,
    output logic               o_p1_ack,
    output logic               o_p1_nack,
    output logic               o_p2_ack,
    output logic               o_p2_nack,
    input  logic [2:0]         i_bomb_id,
    output logic               o_rd_active,
    output logic               o_rd_blast,
    output logic               o_rd_owner,
    output logic [COORD_W-1:0] o_rd_x,
    output logic [COORD_W-1:0] o_rd_y,
    output logic [1:0]         o_p1_live,
    output logic [1:0]         o_p2_live,
    output logic               o_detonate
);
    localparam int TW = $clog2((FUSE_FRAMES > BLAST_FRAMES ? FUSE_FRAMES : BLAST_FRAMES) + 1);

    slot_state_t          w_state [NUM_SLOTS];
    logic                 w_owner [NUM_SLOTS];
    logic [COORD_W-1:0]   w_x [NUM_SLOTS];
    logic [COORD_W-1:0]   w_y [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_force, w_enter;
    logic                 r_rr, r_p1_ack, r_p1_nack, r_p2_ack, r_p2_nack, r_detonate;
    logic                 w_p1_req, w_p2_req, w_any, w_sel, w_has_idle, w_dup, w_grant;
    logic [COORD_W-1:0]   w_sel_x, w_sel_y;
    logic [2:0]           w_idx;
    logic [1:0]           w_p1_cnt, w_p2_cnt, w_sel_cnt;

    // A player's request is ignored while its previous result is still on the outputs.
    assign w_p1_req  = i_p1_place & ~(r_p1_ack | r_p1_nack);
    assign w_p2_req  = i_p2_place & ~(r_p2_ack | r_p2_nack);
    assign w_any     = w_p1_req | w_p2_req;
    assign w_sel     = (w_p1_req & w_p2_req) ? r_rr : w_p2_req;
    assign w_sel_x   = w_sel ? i_p2_x : i_p1_x;
    assign w_sel_y   = w_sel ? i_p2_y : i_p1_y;
    assign w_sel_cnt = w_sel ? w_p2_cnt : w_p1_cnt;
    assign w_grant   = w_any & ~i_game_clear & w_has_idle & ~w_dup & (w_sel_cnt < 2'(MAX_PER_PLAYER));

    always_comb begin
        w_has_idle = 1'b0;
        w_idx      = '0;
        w_dup      = 1'b0;
        w_p1_cnt   = '0;
        w_p2_cnt   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_state[i] == IDLE) begin
                w_has_idle = 1'b1;
                w_idx      = 3'(i);
            end else begin
                w_dup    = w_dup | ((w_x[i] == w_sel_x) && (w_y[i] == w_sel_y));
                w_p1_cnt = w_p1_cnt + 2'(w_owner[i] == OWNER_P1);
                w_p2_cnt = w_p2_cnt + 2'(w_owner[i] == OWNER_P2);
            end
        end
    end

`ifdef CHAIN_REACTION_EN
    function automatic logic f_near(input logic [COORD_W-1:0] ax, ay, bx, by);
        logic [COORD_W-1:0] dx, dy;
        dx = (ax > bx) ? ax - bx : bx - ax;
        dy = (ay > by) ? ay - by : by - ay;
        return (ax == bx && dy <= COORD_W'(2)) || (ay == by && dx <= COORD_W'(2));
    endfunction

    always_comb begin
        w_force = '0;
        for (int j = 0; j < NUM_SLOTS; j++)
            for (int i = 0; i < NUM_SLOTS; i++)
                w_force[j] = w_force[j] | (w_enter[i] && f_near(w_x[i], w_y[i], w_x[j], w_y[j]));
    end
`else
    assign w_force = '0;
`endif

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        bomb_slot #(
            .COORD_W(COORD_W), .FUSE_FRAMES(FUSE_FRAMES), .BLAST_FRAMES(BLAST_FRAMES), .TW(TW)
        ) u_slot (
            .clock(clock), .reset(reset), .i_clear(i_game_clear),
            .i_load(w_grant && w_idx == 3'(g)), .i_tick(i_tick), .i_force(w_force[g]),
            .i_owner(w_sel), .i_x(w_sel_x), .i_y(w_sel_y),
            .o_state(w_state[g]), .o_owner(w_owner[g]), .o_x(w_x[g]), .o_y(w_y[g]),
            .o_enter_blast(w_enter[g])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr       <= OWNER_P1;
            r_p1_ack   <= 1'b0;
            r_p1_nack  <= 1'b0;
            r_p2_ack   <= 1'b0;
            r_p2_nack  <= 1'b0;
            r_detonate <= 1'b0;
        end else begin
            r_rr       <= i_game_clear ? OWNER_P1 : r_rr ^ (w_p1_req & w_p2_req);
            r_p1_ack   <= w_grant & ~w_sel;
            r_p1_nack  <= w_any & ~i_game_clear & ~w_grant & ~w_sel;
            r_p2_ack   <= w_grant & w_sel;
            r_p2_nack  <= w_any & ~i_game_clear & ~w_grant & w_sel;
            r_detonate <= |w_enter;
        end
    end

    always_comb begin
        o_rd_active = 1'b0;
        o_rd_blast  = 1'b0;
        o_rd_owner  = 1'b0;
        o_rd_x      = '0;
        o_rd_y      = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (i_bomb_id == 3'(i)) begin
                o_rd_active = w_state[i] != IDLE;
                o_rd_blast  = w_state[i] == BLAST;
                o_rd_owner  = w_owner[i];
                o_rd_x      = w_x[i];
                o_rd_y      = w_y[i];
            end
        end
    end

    assign o_p1_ack   = r_p1_ack;
    assign o_p1_nack  = r_p1_nack;
    assign o_p2_ack   = r_p2_ack;
    assign o_p2_nack  = r_p2_nack;
    assign o_p1_live  = w_p1_cnt;
    assign o_p2_live  = w_p2_cnt;
    assign o_detonate = r_detonate;
endmodule
